// File: rtl/gt_rx_capture.sv
// Sync-word triggered capture of one GT RX channel into a read-first RAM; 1-cycle readback, no backpressure.
// Optional sync-search timeout enabled by defining GT_RX_TIMEOUT_EN.
module gt_rx_capture #(
  parameter int                          CHN_NUM         = 6,
  parameter int                          USER_DATA_WIDTH = 32,
  parameter int                          RAM_DEPTH       = 1024,
  parameter logic [USER_DATA_WIDTH-1:0]  SYNC_WORD       = 32'hBCBC_50C5,
  parameter int                          TIMEOUT_CYCLES  = 2**20,
  localparam int                         AW              = $clog2(RAM_DEPTH)
) (
  input  logic                               gt_clk,
  input  logic                               gt_reset,
  input  logic [CHN_NUM*USER_DATA_WIDTH-1:0] rx_data,
  input  logic [CHN_NUM-1:0]                 rx_valid,
  input  logic [2:0]                         reg_chn,
  input  logic                               reg_start,
  input  logic                               reg_reset,
  input  logic [AW:0]                        reg_cap_len,
  input  logic [AW-1:0]                      ram_addr,
  output logic [USER_DATA_WIDTH-1:0]         ram_data,
  output logic                               cap_busy,
  output logic                               sync_found,
  output logic                               cap_done,
  output logic                               timeout,
  output logic [AW:0]                        cap_count
);

  localparam int W = USER_DATA_WIDTH;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(RAM_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_CAPTURE,
    ST_DONE,
    ST_TIMEOUT
  } state_t;

  state_t         state_q, state_d;
  logic           reg_start_q;
  logic [2:0]     chn_q, chn_d;
  logic [AW:0]    len_q, len_d;
  logic [AW:0]    cap_count_q, cap_count_d;
  logic           sync_found_q, sync_found_d;
  logic           cap_done_q, cap_done_d;
  logic           timeout_q, timeout_d;
  logic [W-1:0]   ram_data_q, ram_data_d;
  logic [W-1:0]   ram_q [RAM_DEPTH];

  logic           start_edge;
  logic [W-1:0]   sel_data;
  logic           sel_vld;
  logic           is_sync;
  logic           wr_en;
  logic [2:0]     chn_eff;
  logic [AW:0]    len_eff;

`ifdef GT_RX_TIMEOUT_EN
  logic [31:0]    to_cnt_q, to_cnt_d;
`endif

  assign start_edge = reg_start & ~reg_start_q;
  assign sel_data   = rx_data[chn_q*W +: W];
  assign sel_vld    = rx_valid[chn_q];
  assign is_sync    = sel_vld && (sel_data == SYNC_WORD);

  // Out-of-range channels fall back to 0; zero or oversize lengths mean a full RAM.
  assign chn_eff = (32'(reg_chn) < CHN_NUM) ? reg_chn : 3'd0;
  assign len_eff = ((reg_cap_len == '0) || (32'(reg_cap_len) > RAM_DEPTH)) ? DEPTH_L : reg_cap_len;

  always_comb begin
    state_d      = state_q;
    chn_d        = chn_q;
    len_d        = len_q;
    cap_count_d  = cap_count_q;
    sync_found_d = sync_found_q;
    cap_done_d   = cap_done_q;
    timeout_d    = timeout_q;
    wr_en        = 1'b0;
    ram_data_d   = ram_q[ram_addr];
`ifdef GT_RX_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
`endif

    if (reg_reset) begin
      state_d      = ST_IDLE;
      cap_count_d  = '0;
      sync_found_d = 1'b0;
      cap_done_d   = 1'b0;
      timeout_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          if (start_edge) begin
            state_d      = ST_SEARCH;
            chn_d        = chn_eff;
            len_d        = len_eff;
            cap_count_d  = '0;
            sync_found_d = 1'b0;
            cap_done_d   = 1'b0;
            timeout_d    = 1'b0;
`ifdef GT_RX_TIMEOUT_EN
            to_cnt_d     = '0;
`endif
          end
        end
        ST_SEARCH: begin
          if (is_sync) begin
            state_d      = ST_CAPTURE;
            sync_found_d = 1'b1;
          end
`ifdef GT_RX_TIMEOUT_EN
          else if (to_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            state_d   = ST_TIMEOUT;
            timeout_d = 1'b1;
          end else begin
            to_cnt_d  = to_cnt_q + 32'd1;
          end
`endif
        end
        ST_CAPTURE: begin
          if (sel_vld && (cap_count_q < DEPTH_L)) begin
            wr_en       = 1'b1;
            cap_count_d = cap_count_q + 1'b1;
            if (cap_count_d == len_q) begin
              state_d    = ST_DONE;
              cap_done_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge gt_clk) begin
    if (gt_reset) begin
      state_q      <= ST_IDLE;
      reg_start_q  <= 1'b0;
      chn_q        <= 3'd0;
      len_q        <= DEPTH_L;
      cap_count_q  <= '0;
      sync_found_q <= 1'b0;
      cap_done_q   <= 1'b0;
      timeout_q    <= 1'b0;
      ram_data_q   <= '0;
`ifdef GT_RX_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      reg_start_q  <= reg_start;
      chn_q        <= chn_d;
      len_q        <= len_d;
      cap_count_q  <= cap_count_d;
      sync_found_q <= sync_found_d;
      cap_done_q   <= cap_done_d;
      timeout_q    <= timeout_d;
      ram_data_q   <= ram_data_d;
`ifdef GT_RX_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  // RAM is never reset; the registered read sees pre-write contents on a collision.
  always_ff @(posedge gt_clk) begin
    if (wr_en) begin
      ram_q[cap_count_q[AW-1:0]] <= sel_data;
    end
  end

  assign ram_data   = ram_data_q;
  assign cap_busy   = (state_q == ST_SEARCH) || (state_q == ST_CAPTURE);
  assign sync_found = sync_found_q;
  assign cap_done   = cap_done_q;
  assign timeout    = timeout_q;
  assign cap_count  = cap_count_q;

endmodule

// File: tb/tb_gt_rx_capture.sv
// Directed self-checking bench for gt_rx_capture; timeout checks follow GT_RX_TIMEOUT_EN.
module tb_gt_rx_capture;

  localparam int CHN = 6;
  localparam int W   = 32;
  localparam int AW  = 10;
  localparam logic [31:0] SYNC = 32'hBCBC_50C5;

  logic              gt_clk = 1'b0;
  logic              gt_reset;
  logic [CHN*W-1:0]  rx_data;
  logic [CHN-1:0]    rx_valid;
  logic [2:0]        reg_chn;
  logic              reg_start;
  logic              reg_reset;
  logic [AW:0]       reg_cap_len;
  logic [AW-1:0]     ram_addr;
  logic [W-1:0]      ram_data;
  logic              cap_busy;
  logic              sync_found;
  logic              cap_done;
  logic              timeout;
  logic [AW:0]       cap_count;

  int tests_run    = 0;
  int tests_failed = 0;

  gt_rx_capture #(
    .CHN_NUM        (CHN),
    .USER_DATA_WIDTH(W),
    .RAM_DEPTH      (1024),
    .SYNC_WORD      (SYNC),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .gt_clk     (gt_clk),
    .gt_reset   (gt_reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .reg_chn    (reg_chn),
    .reg_start  (reg_start),
    .reg_reset  (reg_reset),
    .reg_cap_len(reg_cap_len),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .cap_busy   (cap_busy),
    .sync_found (sync_found),
    .cap_done   (cap_done),
    .timeout    (timeout),
    .cap_count  (cap_count)
  );

  always #5 gt_clk = ~gt_clk;

  task automatic tick();
    @(posedge gt_clk);
    #1;
  endtask

  // Selected channel gets d; the others carry filler so a wrong mux shows up.
  task automatic send(input int c, input logic [31:0] d, input logic v);
    for (int i = 0; i < CHN; i++) rx_data[i*W +: W] = (i == c) ? d : (32'hDEAD_0000 | 32'(i));
    rx_valid = v ? 6'(1 << c) : 6'd0;
    tick();
    rx_valid = '0;
  endtask

  task automatic start(input logic [2:0] c, input logic [AW:0] len);
    reg_chn     = c;
    reg_cap_len = len;
    reg_start   = 1'b1;
    tick();
    reg_start   = 1'b0;
  endtask

  task automatic test_reset();
    gt_reset = 1'b1;
    repeat (3) tick();
    tests_run++; if (ram_data !== 32'h0) begin tests_failed++; $display("FAIL rst_ram_data: got %h want 0", ram_data); end
    tests_run++; if (cap_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", cap_busy); end
    tests_run++; if (sync_found !== 1'b0) begin tests_failed++; $display("FAIL rst_sync: got %b want 0", sync_found); end
    tests_run++; if (cap_done !== 1'b0) begin tests_failed++; $display("FAIL rst_done: got %b want 0", cap_done); end
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    tests_run++; if (cap_count !== 11'd0) begin tests_failed++; $display("FAIL rst_count: got %0d want 0", cap_count); end
    gt_reset = 1'b0;
    tick();
  endtask

  task automatic test_ch3_len4();
    start(3'd3, 11'd4);
    tests_run++; if (cap_busy !== 1'b1) begin tests_failed++; $display("FAIL ch3_busy_after_start: got %b want 1", cap_busy); end
    send(3, SYNC, 1'b1);
    tests_run++; if (sync_found !== 1'b1) begin tests_failed++; $display("FAIL ch3_sync_found: got %b want 1", sync_found); end
    tests_run++; if (cap_count !== 11'd0) begin tests_failed++; $display("FAIL ch3_sync_not_stored: got %0d want 0", cap_count); end
    for (int i = 1; i <= 3; i++) send(3, 32'(i), 1'b1);
    tests_run++; if (cap_done !== 1'b0 || cap_count !== 11'd3) begin tests_failed++; $display("FAIL ch3_before_last: done %b count %0d want 0/3", cap_done, cap_count); end
    send(3, 32'd4, 1'b1);
    tests_run++; if (cap_done !== 1'b1 || cap_busy !== 1'b0) begin tests_failed++; $display("FAIL ch3_done: done %b busy %b want 1/0", cap_done, cap_busy); end
    tests_run++; if (cap_count !== 11'd4) begin tests_failed++; $display("FAIL ch3_count: got %0d want 4", cap_count); end
    send(3, 32'd5, 1'b1);
    tests_run++; if (cap_count !== 11'd4) begin tests_failed++; $display("FAIL ch3_no_extra: got %0d want 4", cap_count); end
    for (int i = 0; i < 4; i++) begin
      ram_addr = AW'(i);
      tick();
      tests_run++; if (ram_data !== 32'(i + 1)) begin tests_failed++; $display("FAIL ch3_ram[%0d]: got %h want %h", i, ram_data, 32'(i + 1)); end
    end
    ram_addr = 10'd4;
    tick();
    tests_run++; if (ram_data === 32'd5) begin tests_failed++; $display("FAIL ch3_ram[4]: got %h, word 5 must not be stored", ram_data); end
  endtask

  task automatic test_valid_gaps();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'hA0A0_0001; exp_w[1] = 32'hB0B0_0002;
    exp_w[2] = 32'hC0C0_0003; exp_w[3] = 32'hD0D0_0004;
    start(3'd1, 11'd4);
    tests_run++; if (cap_done !== 1'b0 || cap_count !== 11'd0) begin tests_failed++; $display("FAIL gap_restart_clear: done %b count %0d want 0/0", cap_done, cap_count); end
    send(1, SYNC, 1'b1);
    send(1, exp_w[0], 1'b1);
    send(1, 32'h0BAD_0BAD, 1'b0);
    send(1, exp_w[1], 1'b1);
    tests_run++; if (cap_count !== 11'd2) begin tests_failed++; $display("FAIL gap_count_mid: got %0d want 2", cap_count); end
    reg_start = 1'b1;
    send(1, exp_w[2], 1'b1);
    reg_start = 1'b0;
    tests_run++; if (cap_count !== 11'd3 || sync_found !== 1'b1) begin tests_failed++; $display("FAIL gap_start_ignored: count %0d sync %b want 3/1", cap_count, sync_found); end
    send(1, 32'h0BAD_0BAD, 1'b0);
    send(1, exp_w[3], 1'b1);
    tests_run++; if (cap_done !== 1'b1 || cap_count !== 11'd4) begin tests_failed++; $display("FAIL gap_done: done %b count %0d want 1/4", cap_done, cap_count); end
    for (int i = 0; i < 4; i++) begin
      ram_addr = AW'(i);
      tick();
      tests_run++; if (ram_data !== exp_w[i]) begin tests_failed++; $display("FAIL gap_ram[%0d]: got %h want %h", i, ram_data, exp_w[i]); end
    end
  endtask

  task automatic test_channel_select();
    start(3'd5, 11'd4);
    send(2, SYNC, 1'b1);
    tests_run++; if (sync_found !== 1'b0 || cap_busy !== 1'b1) begin tests_failed++; $display("FAIL chsel_wrong_chn: sync %b busy %b want 0/1", sync_found, cap_busy); end
    send(5, SYNC, 1'b0);
    tests_run++; if (sync_found !== 1'b0) begin tests_failed++; $display("FAIL chsel_invalid_sync: got %b want 0", sync_found); end
    reg_reset = 1'b1; tick(); reg_reset = 1'b0;
    start(3'd7, 11'd4);
    send(1, SYNC, 1'b1);
    tests_run++; if (sync_found !== 1'b0) begin tests_failed++; $display("FAIL chsel7_chn1: got %b want 0", sync_found); end
    send(0, SYNC, 1'b1);
    tests_run++; if (sync_found !== 1'b1) begin tests_failed++; $display("FAIL chsel7_as_chn0: got %b want 1", sync_found); end
    reg_reset = 1'b1; tick(); reg_reset = 1'b0;
  endtask

  task automatic test_soft_reset();
    start(3'd2, 11'd8);
    send(2, SYNC, 1'b1);
    send(2, 32'h0000_0011, 1'b1);
    send(2, 32'h0000_0022, 1'b1);
    tests_run++; if (cap_count !== 11'd2) begin tests_failed++; $display("FAIL srst_pre_count: got %0d want 2", cap_count); end
    reg_reset = 1'b1; tick(); reg_reset = 1'b0;
    tests_run++; if (cap_busy !== 1'b0 || sync_found !== 1'b0 || cap_done !== 1'b0 || cap_count !== 11'd0) begin
      tests_failed++; $display("FAIL srst_flags: busy %b sync %b done %b count %0d want all 0", cap_busy, sync_found, cap_done, cap_count);
    end
    ram_addr = 10'd0; tick();
    tests_run++; if (ram_data !== 32'h11) begin tests_failed++; $display("FAIL srst_ram0_kept: got %h want 11", ram_data); end
    ram_addr = 10'd1; tick();
    tests_run++; if (ram_data !== 32'h22) begin tests_failed++; $display("FAIL srst_ram1_kept: got %h want 22", ram_data); end
    start(3'd2, 11'd2);
    send(2, SYNC, 1'b1);
    ram_addr = 10'd0;
    send(2, 32'h0000_0033, 1'b1);
    tests_run++; if (ram_data !== 32'h11) begin tests_failed++; $display("FAIL read_first_old: got %h want 11", ram_data); end
    send(2, 32'h0000_0044, 1'b1);
    tests_run++; if (ram_data !== 32'h33) begin tests_failed++; $display("FAIL read_first_new: got %h want 33", ram_data); end
    tests_run++; if (cap_done !== 1'b1 || cap_count !== 11'd2) begin tests_failed++; $display("FAIL srst_recapture: done %b count %0d want 1/2", cap_done, cap_count); end
    ram_addr = 10'd1; tick();
    tests_run++; if (ram_data !== 32'h44) begin tests_failed++; $display("FAIL srst_ram1_new: got %h want 44", ram_data); end
  endtask

  task automatic test_full_length();
    start(3'd4, 11'd0);
    send(4, SYNC, 1'b1);
    for (int i = 0; i < 1023; i++) send(4, 32'h1000 + 32'(i), 1'b1);
    tests_run++; if (cap_done !== 1'b0 || cap_count !== 11'd1023) begin tests_failed++; $display("FAIL full_before_last: done %b count %0d want 0/1023", cap_done, cap_count); end
    send(4, 32'h13FF, 1'b1);
    tests_run++; if (cap_done !== 1'b1 || cap_count !== 11'd1024) begin tests_failed++; $display("FAIL full_done: done %b count %0d want 1/1024", cap_done, cap_count); end
    for (int i = 0; i < 3; i++) send(4, 32'hFFFF_0000, 1'b1);
    tests_run++; if (cap_count !== 11'd1024) begin tests_failed++; $display("FAIL full_saturate: got %0d want 1024", cap_count); end
    ram_addr = 10'd0; tick();
    tests_run++; if (ram_data !== 32'h1000) begin tests_failed++; $display("FAIL full_ram0: got %h want 1000", ram_data); end
    ram_addr = 10'd512; tick();
    tests_run++; if (ram_data !== 32'h1200) begin tests_failed++; $display("FAIL full_ram512: got %h want 1200", ram_data); end
    ram_addr = 10'd1023; tick();
    tests_run++; if (ram_data !== 32'h13FF) begin tests_failed++; $display("FAIL full_ram1023: got %h want 13ff", ram_data); end
  endtask

  task automatic test_timeout();
    start(3'd0, 11'd4);
`ifdef GT_RX_TIMEOUT_EN
    repeat (15) tick();
    tests_run++; if (timeout !== 1'b0 || cap_busy !== 1'b1) begin tests_failed++; $display("FAIL to_early: timeout %b busy %b want 0/1", timeout, cap_busy); end
    tick();
    tests_run++; if (timeout !== 1'b1 || cap_busy !== 1'b0 || cap_done !== 1'b0) begin
      tests_failed++; $display("FAIL to_fire: timeout %b busy %b done %b want 1/0/0", timeout, cap_busy, cap_done);
    end
`else
    repeat (1000) tick();
    tests_run++; if (cap_busy !== 1'b1 || timeout !== 1'b0 || sync_found !== 1'b0) begin
      tests_failed++; $display("FAIL no_to_search: busy %b timeout %b sync %b want 1/0/0", cap_busy, timeout, sync_found);
    end
`endif
  endtask

  initial begin
    gt_reset    = 1'b1;
    rx_data     = '0;
    rx_valid    = '0;
    reg_chn     = 3'd0;
    reg_start   = 1'b0;
    reg_reset   = 1'b0;
    reg_cap_len = '0;
    ram_addr    = '0;
    test_reset();
    test_ch3_len4();
    test_valid_gaps();
    test_channel_select();
    test_soft_reset();
    test_full_length();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gt_rx_capture.md
# gt_rx_capture

Receive-side companion to the GT TX pattern path. Watches the parallel user data of one selected GT receive channel in the GT user clock domain and waits for a sync word. After the sync word it captures a programmable number of 32-bit words into an internal RAM. Software reads the RAM back through the register block, so a looped-back TX pattern can be checked word for word. Control and status are already in the `gt_clk` domain; CDC to the AXI-Lite register map is handled outside this block.

## Interface
Parameters:
- `CHN_NUM`, 6: number of GT channels on `rx_data`.
- `USER_DATA_WIDTH`, 32: width of each channel word (W).
- `RAM_DEPTH`, 1024: capture RAM depth, power of two; AW = log2(RAM_DEPTH).
- `SYNC_WORD`, 32'hBCBC_50C5: word that opens a capture.
- `TIMEOUT_CYCLES`, 2**20: sync search limit (only with `GT_RX_TIMEOUT_EN`).

Ports:
- `gt_clk`  in  1  GT user clock; the only clock.
- `gt_reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  CHN_NUM*W  channel c occupies bits [c*W +: W].
- `rx_valid`  in  CHN_NUM  per-channel word valid.
- `reg_chn`  in  3  channel select; latched on start; values ≥ CHN_NUM select channel 0.
- `reg_start`  in  1  rising edge arms a capture.
- `reg_reset`  in  1  level; soft abort to IDLE.
- `reg_cap_len`  in  AW+1  words to capture; 0 or > RAM_DEPTH means RAM_DEPTH.
- `ram_addr`  in  AW  readback address.
- `ram_data`  out  W  readback data, 1-cycle latency.
- `cap_busy`  out  1  capture in progress (SEARCH or CAPTURE).
- `sync_found`  out  1  sync word seen in this run.
- `cap_done`  out  1  requested length captured.
- `timeout`  out  1  sync search timed out.
- `cap_count`  out  AW+1  words written in this run.

## Operation
- Start detection: `reg_start` is registered, and the rising edge is `reg_start & ~reg_start_q`.
- States: IDLE, SEARCH, CAPTURE, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT + start edge → SEARCH:
  - latch `reg_chn` and the effective length;
  - clear `cap_count`, `sync_found`, `cap_done`, `timeout`.
- Start edges in SEARCH or CAPTURE are ignored.
- SEARCH: when `rx_valid[chn]` is high and the word equals `SYNC_WORD`, go to CAPTURE and set `sync_found`. The sync word itself is not stored.
- CAPTURE: each valid word is written to RAM at `cap_count[AW-1:0]`, then `cap_count` increments.
  - Cycles with valid low produce no write.
  - Further sync words are stored as ordinary data.
  - When the write brings `cap_count` to the length, go to DONE and set `cap_done`.
- DONE and TIMEOUT hold their flags until the next start edge, `reg_reset`, or `gt_reset`.
- Priority: `gt_reset` > `reg_reset` > start edge.
  - Both resets force IDLE and clear all status outputs.
  - RAM contents are never cleared.
- Readback is independent of state. On a same-cycle write and read of the same address, the read returns the old data (read-first).
- `cap_count` saturates at RAM_DEPTH; there is no address wrap within a run.

## Timing
- Reset values: `ram_data`=0, `cap_busy`=0, `sync_found`=0, `cap_done`=0, `timeout`=0, `cap_count`=0, state IDLE.
- Start edge sampled at cycle T → `cap_busy`=1 from T+1; a sync word at T+1 is eligible.
- Sync word accepted at cycle N → `sync_found`=1 at N+1; a valid word at N+1 is written to address 0.
- Last word written at cycle M → `cap_done`=1 and `cap_busy`=0 at M+1; `cap_count` equals the length at M+1.
- `ram_addr` at cycle K → `ram_data` valid at K+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `GT_RX_TIMEOUT_EN` defined:
  - a cycle counter runs in SEARCH and is cleared on entry;
  - when it reaches TIMEOUT_CYCLES-1 with no sync word, go to TIMEOUT and set `timeout`=1 (`cap_done` stays 0);
  - a sync word on that same cycle wins.
- Not defined: there is no counter, SEARCH waits indefinitely, TIMEOUT is unreachable, and `timeout` is tied to 0.

## Test plan
- Channel 3, length 4: drive `SYNC_WORD` then 1,2,3,4,5 → RAM[0..3]=1..4, `cap_count`=4, `cap_done`=1 one cycle after word 4, and 5 is not stored.
- Valid gaps: sync, then valid pattern 1,0,1,1,0,1 with data A,x,B,C,x,D and length 4 → RAM[0..3]=A,B,C,D.
- Wrong channel: sync on channel 2 while channel 5 is selected → stays in SEARCH, `sync_found`=0; `reg_chn`=7 behaves as channel 0.
- `reg_reset` asserted mid-CAPTURE after 2 words → IDLE next cycle, flags 0, RAM[0..1] retained; a new start edge captures again from address 0.
- `reg_cap_len`=0 → exactly 1024 words captured; `cap_count`=1024 and saturates; extra valid words are not written.
- With `GT_RX_TIMEOUT_EN` and TIMEOUT_CYCLES=16, no sync → `timeout`=1 exactly 16 cycles after SEARCH entry; without the macro, still SEARCH after 1000 cycles.
